// File: rtl/pdm_multi_decim.sv
// Multi-channel PDM decimator: counts ones per channel over DECIM valid samples
// and presents the window counts through a single-entry valid/ready output register.

module pdm_multi_decim_lane #(
    parameter int ACCUM_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  count_en,
    input  logic                  clr,
    input  logic                  wrap,
    input  logic                  bit_in,
    output logic [ACCUM_BITS-1:0] sum
);
    logic [ACCUM_BITS-1:0] acc;

    // Sum including the current bit, so the completing sample is part of the result
    assign sum = acc + ACCUM_BITS'(bit_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        acc <= '0;
        else if (clr)      acc <= '0;
        else if (count_en) acc <= wrap ? '0 : sum;
    end
endmodule

module pdm_multi_decim #(
    parameter int CHANNELS   = 2,
    parameter int DECIM      = 16,
    parameter int ACCUM_BITS = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sample_valid,
    input  logic [CHANNELS-1:0]            data,
    input  logic                           sync,
    output logic [CHANNELS*ACCUM_BITS-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           overrun,
    input  logic                           clear_overrun
);
    localparam int CW = (DECIM > 2) ? $clog2(DECIM) : 1;

    generate
        if (!((1 << ACCUM_BITS) > DECIM)) begin : g_bad_width
            $error("pdm_multi_decim: 2**ACCUM_BITS must exceed DECIM");
        end
    endgenerate

    logic [CW-1:0]                          cnt;
    logic [CHANNELS-1:0][ACCUM_BITS-1:0]    sum;
    logic [CHANNELS-1:0][ACCUM_BITS-1:0]    out_reg;
    logic                                   count_en;
    logic                                   complete;
    logic                                   xfer;
    logic                                   load;
    logic                                   drop;

    assign count_en = sample_valid & ~sync;
    assign complete = count_en & (cnt == CW'(DECIM - 1));
    assign xfer     = out_valid & out_ready;
    assign load     = complete & (~out_valid | out_ready);
    assign drop     = complete & out_valid & ~out_ready;
    assign out_data = out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt <= '0;
        else if (sync)     cnt <= '0;
        else if (count_en) cnt <= (cnt == CW'(DECIM - 1)) ? '0 : cnt + 1'b1;
    end

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_lane
            pdm_multi_decim_lane #(.ACCUM_BITS(ACCUM_BITS)) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .count_en (count_en),
                .clr      (sync),
                .wrap     (complete),
                .bit_in   (data[i]),
                .sum      (sum[i])
            );
        end
    endgenerate

    // A held, unconsumed result has priority; a completing window with nowhere to go is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                out_reg   <= sum;
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            if (drop)               overrun <= 1'b1;
            else if (clear_overrun) overrun <= 1'b0;
        end
    end
endmodule

// File: doc/pdm_multi_decim.md
PDM_MULTI_DECIM -- requirements
Module: pdm_multi_decim

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent PDM bit streams accumulated in parallel; legal range >= 1.
REQ-002 Parameter DECIM, default 16: number of valid samples per output window; legal range >= 2.
REQ-003 Parameter ACCUM_BITS, default 5: width of each per-channel count; SHALL satisfy 2^ACCUM_BITS > DECIM; an elaboration-time check SHALL fail otherwise.
REQ-004 clk  input  1  single clock for all state.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sample_valid  input  1  one-cycle strobe qualifying data; may be asserted on consecutive cycles.
REQ-007 data  input  CHANNELS  one PDM bit per channel, sampled only when sample_valid=1.
REQ-008 sync  input  1  restarts the current window; any partial window is discarded.
REQ-009 out_data  output  CHANNELS*ACCUM_BITS  packed window counts, channel 0 in bits [ACCUM_BITS-1:0].
REQ-010 out_valid  output  1  out_data holds an unconsumed result.
REQ-011 out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1.
REQ-012 overrun  output  1  sticky flag: a completed window was dropped.
REQ-013 clear_overrun  input  1  synchronous clear of overrun.

Function
REQ-014 A window counter SHALL count 0..DECIM-1, advancing on each clk edge where sample_valid=1 and sync=0, and wrapping to 0 after DECIM-1.
REQ-015 Each channel accumulator SHALL add data[i] (0 or 1) on every counted sample; a count is unsigned, range 0..DECIM, never saturating or wrapping.
REQ-016 Window completion: the edge where sample_valid=1, sync=0 and counter=DECIM-1.
REQ-017 At completion, the final per-channel sum (accumulator plus current data[i]) SHALL be offered to the output register, and all accumulators SHALL clear to 0 in the same edge.
REQ-018 Latency: out_valid SHALL rise on the clk edge of the completing sample, i.e. visible in the cycle after the DECIM-th strobe.
REQ-019 Output handshake: a transfer occurs on any edge with out_valid=1 and out_ready=1; out_valid SHALL deassert after the transfer unless a new result loads on the same edge.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_valid SHALL remain stable.
REQ-021 Completion with output register empty, or with a transfer on the same edge: new result loads, out_valid=1, overrun unchanged.
REQ-022 Completion with out_valid=1 and out_ready=0: new result SHALL be dropped, held result retained, overrun set to 1.
REQ-023 sync=1 SHALL clear the counter and all accumulators on that edge and ignore a coincident sample_valid; no completion occurs on that edge.
REQ-024 sync SHALL NOT affect out_data, out_valid or overrun.
REQ-025 clear_overrun=1 clears overrun, except when a drop occurs on the same edge: set wins.
REQ-026 The output register is the only output path; there is no additional buffering (depth 1).

Reset
REQ-027 rst_n=0 SHALL asynchronously force counter, accumulators and out_data to 0, and out_valid and overrun to 0.
REQ-028 Reset asserted mid-window SHALL discard the partial window; the first window after release starts at counter=0.
REQ-029 Inputs are ignored while rst_n=0; normal operation resumes on the first clk edge with rst_n=1.

Verification (CHANNELS=2, DECIM=16, ACCUM_BITS=5)
REQ-030 Reset: hold rst_n=0 with activity on all inputs -> out_data=0, out_valid=0, overrun=0 throughout.
REQ-031 Count: 16 strobes, ch0 bits 16'h1234 LSB-first, ch1 bits 16'h5432, out_ready=1 -> one cycle after 16th strobe out_valid=1 for one cycle, out_data=10'h0C5 (ch1=6, ch0=5).
REQ-032 Full scale and back-to-back: 32 consecutive-cycle strobes, all data=1 -> two results, each out_data=10'h210 (16,16); no overrun.
REQ-033 Backpressure: out_ready=0 across two windows (0x1234/0x5432 then all zeros) -> out_data stays 10'h0C5, overrun=1 after second completion; raise out_ready -> one transfer of 10'h0C5, then out_valid=0; clear_overrun -> overrun=0.
REQ-034 Sync: 7 strobes of ones, sync pulse coincident with an 8th strobe, then 16 strobes of ones -> exactly one result, out_data=10'h210, emitted after the 16 post-sync strobes.
REQ-035 Reset mid-window: 9 strobes of ones, pulse rst_n low, then 16 strobes of zeros -> single result out_data=0, out_valid pulses once.
